uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_arbiter_if.sv | 31 +++
 rtl/uart_rr_pick.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 107 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter slice.
// Contents: arbiter FSM state enumeration, byte width, default start timeout.
package uart_pkg;

    localparam int unsigned BYTE_W                = 8;
    localparam int unsigned START_TIMEOUT_DEFAULT = 64;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_LOAD       = 2'd1,
        ST_WAIT_START = 2'd2,
        ST_WAIT_END   = 2'd3
    } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bundle between byte requesters, the arbiter and the existing UART transmitter.
// master: arbiter side (drives ack, tx_load, tx_data, grant_id, active, err_timeout)
// slave : environment side (drives req, req_data, tx_busy)
interface uart_tx_arbiter_if #(
    parameter int unsigned NREQ = 4
);
    import uart_pkg::*;

    localparam int unsigned ID_W = $clog2(NREQ);

    logic [NREQ-1:0]        req;
    logic [BYTE_W*NREQ-1:0] req_data;
    logic [NREQ-1:0]        ack;
    logic                   tx_load;
    logic [BYTE_W-1:0]      tx_data;
    logic                   tx_busy;
    logic [ID_W-1:0]        grant_id;
    logic                   active;
    logic                   err_timeout;

    modport master (
        input  req, req_data, tx_busy,
        output ack, tx_load, tx_data, grant_id, active, err_timeout
    );

    modport slave (
        output req, req_data, tx_busy,
        input  ack, tx_load, tx_data, grant_id, active, err_timeout
    );

endinterface

// File: rtl/uart_rr_pick.sv
// Combinational round-robin pick: first set req bit searching ptr, ptr+1, ... mod NREQ.
// Ports: req (pending levels), ptr (search start) -> winner (index), valid (any req set).
module uart_rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [ID_W-1:0] winner,
    output logic            valid
);

    // Rotating search; the first hit locks out later candidates.
    always_comb begin
        int unsigned idx;
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(ptr) + k) % NREQ;
            if (!valid && req[ID_W'(idx)]) begin
                valid  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte requesters.
// Ports: clk, rst (sync, active-high), bus (uart_tx_arbiter_if.master):
//   req/req_data in, ack pulse out, tx_load/tx_data to transmitter, tx_busy back,
//   grant_id/active status, err_timeout pulse when the transmitter never starts.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NREQ          = 4,
    parameter int unsigned START_TIMEOUT = START_TIMEOUT_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_arbiter_if.master  bus
);

    localparam int unsigned ID_W  = $clog2(NREQ);
    localparam int unsigned CNT_W = $clog2(START_TIMEOUT) + 1;

    arb_state_e        state;
    logic [ID_W-1:0]   ptr;
    logic [CNT_W-1:0]  cnt;
    logic [ID_W-1:0]   grant_id;
    logic [BYTE_W-1:0] tx_data;
    logic [NREQ-1:0]   ack;
    logic              tx_load;
    logic              active;
    logic              err_timeout;

    logic [ID_W-1:0]   winner;
    logic              pick_valid;

    uart_rr_pick #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_pick (
        .req    (bus.req),
        .ptr    (ptr),
        .winner (winner),
        .valid  (pick_valid)
    );

    // Arbiter FSM; strobes are set on the transition into LOAD so they are
    // registered yet high exactly during the LOAD cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            cnt         <= '0;
            grant_id    <= '0;
            tx_data     <= '0;
            ack         <= '0;
            tx_load     <= 1'b0;
            active      <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            ack         <= '0;
            tx_load     <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant_id <= winner;
                        tx_data  <= bus.req_data[32'(winner)*BYTE_W +: BYTE_W];
                        ptr      <= (winner == ID_W'(NREQ - 1)) ? '0 : winner + ID_W'(1);
                        ack      <= NREQ'(1) << winner;
                        tx_load  <= 1'b1;
                        active   <= 1'b1;
                        state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    cnt   <= '0;
                    state <= ST_WAIT_START;
                end
                ST_WAIT_START: begin
                    if (bus.tx_busy) begin
                        state <= ST_WAIT_END;
                    end else if (cnt == CNT_W'(START_TIMEOUT - 1)) begin
                        err_timeout <= 1'b1;
                        active      <= 1'b0;
                        state       <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_WAIT_END: begin
                    if (!bus.tx_busy) begin
                        active <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    active <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ack         = ack;
    assign bus.tx_load     = tx_load;
    assign bus.tx_data     = tx_data;
    assign bus.grant_id    = grant_id;
    assign bus.active      = active;
    assign bus.err_timeout = err_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset, single grant, round-robin skip and
// fairness, start timeout, reset mid-transfer, serial loopback through a
// bench transmitter/receiver pair (50 clk per bit).
module tb_uart_tx_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NREQ(4)) bus ();

    uart_tx_arbiter #(
        .NREQ          (4),
        .START_TIMEOUT (64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int ack_viol = 0;

    // tx_busy source: 0 = driven directly, 1 = 10-cycle busy model, 2 = serial transmitter
    int   mode     = 0;
    logic busy_drv = 1'b0;
    int   auto_cnt = 0;

    logic       u_busy = 1'b0;
    int         u_cnt  = 0;
    logic [9:0] u_frame = 10'h3FF;
    logic       line;

    logic       rx_act = 1'b0;
    int         rx_t   = 0;
    logic [7:0] rx_sh  = 8'h00;
    logic [7:0] rx_q[$];

    assign bus.tx_busy = (mode == 0) ? busy_drv : (mode == 1) ? (auto_cnt != 0) : u_busy;
    assign line        = u_busy ? u_frame[4'(u_cnt / 50)] : 1'b1;

    always @(posedge clk) begin
        if (rst)                 auto_cnt <= 0;
        else if (bus.tx_load)    auto_cnt <= 10;
        else if (auto_cnt != 0)  auto_cnt <= auto_cnt - 1;
    end

    // Serial transmitter model: start bit, 8 data bits LSB first, stop bit.
    always @(posedge clk) begin
        if (rst) begin
            u_busy <= 1'b0;
        end else if (!u_busy && bus.tx_load && mode == 2) begin
            u_frame <= {1'b1, bus.tx_data, 1'b0};
            u_cnt   <= 0;
            u_busy  <= 1'b1;
        end else if (u_busy) begin
            if (u_cnt == 499) u_busy <= 1'b0;
            else              u_cnt  <= u_cnt + 1;
        end
    end

    // Receiver model sampling mid-bit.
    always @(posedge clk) begin
        if (!rx_act) begin
            if (line == 1'b0) begin
                rx_act <= 1'b1;
                rx_t   <= 1;
            end
        end else begin
            rx_t <= rx_t + 1;
            if (rx_t >= 75 && rx_t <= 425 && (rx_t - 25) % 50 == 0)
                rx_sh[3'((rx_t - 75) / 50)] <= line;
            if (rx_t == 475) begin
                rx_q.push_back(rx_sh);
                rx_act <= 1'b0;
            end
        end
    end

    // ack must be one-hot and coincide with tx_load.
    always @(negedge clk) begin
        if (!rst && (((bus.ack != 4'b0) !== bus.tx_load) || $countones(bus.ack) > 1))
            ack_viol++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_load(input string tag);
        @(negedge clk);
        for (int i = 0; i < 300 && !bus.tx_load; i++) @(negedge clk);
        check({tag, "_load"}, 32'(bus.tx_load), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 2000 && bus.active; i++) @(negedge clk);
        check({tag, "_idle"}, 32'(bus.active), 32'd0);
    endtask

    initial begin
        int n;
        logic [7:0] seq [3];
        seq[0] = 8'h55; seq[1] = 8'h0F; seq[2] = 8'hFF;

        rst = 1'b1;
        bus.req = 4'b0000;
        bus.req_data = 32'h0;
        repeat (3) tick();
        check("rst_active",   32'(bus.active),      32'd0);
        check("rst_load",     32'(bus.tx_load),     32'd0);
        check("rst_ack",      32'(bus.ack),         32'd0);
        check("rst_err",      32'(bus.err_timeout), 32'd0);
        check("rst_grant",    32'(bus.grant_id),    32'd0);
        check("rst_data",     32'(bus.tx_data),     32'd0);
        rst = 1'b0;
        tick();
        check("idle_active",  32'(bus.active),      32'd0);

        // Single requester: strobe in the cycle after req is sampled
        bus.req_data[7:0] = 8'hA5;
        bus.req = 4'b0001;
        tick();
        check("single_load",  32'(bus.tx_load),  32'd1);
        check("single_ack",   32'(bus.ack),      32'h1);
        check("single_grant", 32'(bus.grant_id), 32'd0);
        check("single_data",  32'(bus.tx_data),  32'hA5);
        bus.req = 4'b0000;
        bus.req_data[7:0] = 8'h00;
        tick();
        check("single_load_off", 32'(bus.tx_load), 32'd0);
        check("single_ack_off",  32'(bus.ack),     32'h0);
        check("single_hold1",    32'(bus.tx_data), 32'hA5);
        busy_drv = 1'b1;
        repeat (3) tick();
        check("single_busy_active", 32'(bus.active),  32'd1);
        check("single_hold2",       32'(bus.tx_data), 32'hA5);
        busy_drv = 1'b0;
        tick();
        check("single_done",  32'(bus.active), 32'd0);

        // Skip: ptr=1 after granting 0
        mode = 1;
        bus.req_data = 32'h33_00_00_11;
        bus.req = 4'b1001;
        wait_load("skip1");
        check("skip1_grant", 32'(bus.grant_id), 32'd3);
        check("skip1_ack",   32'(bus.ack),      32'h8);
        check("skip1_data",  32'(bus.tx_data),  32'h33);
        wait_load("skip2");
        check("skip2_grant", 32'(bus.grant_id), 32'd0);
        check("skip2_ack",   32'(bus.ack),      32'h1);
        check("skip2_data",  32'(bus.tx_data),  32'h11);
        bus.req_data[15:8] = 8'h22;
        bus.req = 4'b1111;
        wait_load("skip3");
        check("skip3_grant", 32'(bus.grant_id), 32'd1);
        bus.req = 4'b0000;
        wait_idle("skip");

        // Fairness from a fresh pointer
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req_data = 32'hC3_C2_C1_C0;
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_load($sformatf("fair%0d", k));
            check($sformatf("fair%0d_grant", k), 32'(bus.grant_id), 32'(k % 4));
            check($sformatf("fair%0d_ack", k),   32'(bus.ack),      32'(1 << (k % 4)));
            check($sformatf("fair%0d_data", k),  32'(bus.tx_data),  32'(8'hC0 + k % 4));
        end
        bus.req = 4'b0000;
        wait_idle("fair");

        // Start timeout: pulse 64 cycles after tx_load drops
        mode = 0;
        busy_drv = 1'b0;
        bus.req = 4'b0010;
        wait_load("to");
        check("to_grant", 32'(bus.grant_id), 32'd1);
        bus.req = 4'b0000;
        n = 0;
        while (!bus.err_timeout && n < 200) begin
            tick();
            n++;
        end
        check("to_cycles",  32'(n),          32'd65);
        check("to_active",  32'(bus.active), 32'd0);
        tick();
        check("to_err_off", 32'(bus.err_timeout), 32'd0);
        check("to_active2", 32'(bus.active),      32'd0);

        // Reset in WAIT_END: ptr returns to 0
        bus.req = 4'b0100;
        wait_load("rstmid");
        check("rstmid_grant", 32'(bus.grant_id), 32'd2);
        bus.req = 4'b0000;
        busy_drv = 1'b1;
        repeat (3) tick();
        check("rstmid_busy_active", 32'(bus.active), 32'd1);
        rst = 1'b1;
        busy_drv = 1'b0;
        tick();
        check("rstmid_active", 32'(bus.active),  32'd0);
        check("rstmid_ack",    32'(bus.ack),     32'd0);
        check("rstmid_load",   32'(bus.tx_load), 32'd0);
        rst = 1'b0;
        bus.req = 4'b1111;
        wait_load("rstmid_next");
        check("rstmid_next_grant", 32'(bus.grant_id), 32'd0);
        bus.req = 4'b0000;
        busy_drv = 1'b1;
        repeat (2) tick();
        busy_drv = 1'b0;
        wait_idle("rstmid");

        // Serial loopback
        mode = 2;
        for (int b = 0; b < 3; b++) begin
            bus.req_data[7:0] = seq[b];
            bus.req = 4'b0001;
            wait_load($sformatf("loop%0d", b));
            bus.req = 4'b0000;
            wait_idle($sformatf("loop%0d", b));
        end
        for (int i = 0; i < 2000 && rx_q.size() < 3; i++) tick();
        check("loop_count", 32'(rx_q.size()), 32'd3);
        for (int b = 0; b < 3; b++)
            check($sformatf("loop_byte%0d", b),
                  (b < rx_q.size()) ? 32'(rx_q[b]) : 32'h100, 32'(seq[b]));

        check("ack_invariant", 32'(ack_viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
